// File: rtl/clk_tick_pkg.sv
// Shared types and constants for the clk_tick_ctrl clock-enable scheduler.
package clk_tick_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } clk_tick_state_e;

    localparam int unsigned CLK_TICK_DIV_W_DEF = 16;

endpackage

// File: rtl/clk_tick_chan.sv
// One tick channel: shadow/active divisor and enable, period counter, tick register, drain halt.
module clk_tick_chan
    import clk_tick_pkg::*;
#(
    parameter int unsigned DIV_W = CLK_TICK_DIV_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             idle_i,
    input  logic             drain_i,
    input  logic             wr_i,
    input  logic [DIV_W-1:0] wr_div_i,
    input  logic             wr_en_i,
    output logic             tick_o,
    output logic             running_o
);

    logic [DIV_W-1:0] shadow_div_q, shadow_div_d;
    logic             shadow_en_q, shadow_en_d;
    logic [DIV_W-1:0] act_div_q, act_div_d;
    logic             act_en_q, act_en_d;
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic             tick_q, tick_d;
    logic             halted_q, halted_d;
    logic [DIV_W-1:0] last_cnt;
    logic             wrap;

    // A divisor of 0 behaves as 1, so the terminal count is 0 in both cases.
    assign last_cnt  = (act_div_q == '0) ? '0 : act_div_q - DIV_W'(1);
    assign wrap      = (cnt_q == last_cnt);
    assign running_o = act_en_q && !halted_q;
    assign tick_o    = tick_q;

    always_comb begin
        shadow_div_d = shadow_div_q;
        shadow_en_d  = shadow_en_q;
        act_div_d    = act_div_q;
        act_en_d     = act_en_q;
        cnt_d        = cnt_q;
        tick_d       = 1'b0;
        halted_d     = halted_q;

        if (idle_i) begin
            cnt_d    = '0;
            halted_d = 1'b0;
            if (wr_i) begin
                shadow_div_d = wr_div_i;
                shadow_en_d  = wr_en_i;
                act_div_d    = wr_div_i;
                act_en_d     = wr_en_i;
            end
        end else begin
            if (wr_i) begin
                shadow_div_d = wr_div_i;
                shadow_en_d  = wr_en_i;
                // A stopped channel has no period in flight, so it can start right away.
                if (!act_en_q && wr_en_i) begin
                    act_div_d = wr_div_i;
                    act_en_d  = 1'b1;
                    cnt_d     = '0;
                end
            end
            if (running_o) begin
                if (wrap) begin
                    cnt_d     = '0;
                    tick_d    = 1'b1;
                    act_div_d = shadow_div_d;
                    act_en_d  = shadow_en_d;
                    if (drain_i) begin
                        halted_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + DIV_W'(1);
                end
            end else begin
                if (!(wr_i && !act_en_q && wr_en_i)) begin
                    cnt_d = '0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_div_q <= DIV_W'(1);
            shadow_en_q  <= 1'b0;
            act_div_q    <= DIV_W'(1);
            act_en_q     <= 1'b0;
            cnt_q        <= '0;
            tick_q       <= 1'b0;
            halted_q     <= 1'b0;
        end else begin
            shadow_div_q <= shadow_div_d;
            shadow_en_q  <= shadow_en_d;
            act_div_q    <= act_div_d;
            act_en_q     <= act_en_d;
            cnt_q        <= cnt_d;
            tick_q       <= tick_d;
            halted_q     <= halted_d;
        end
    end

endmodule

// File: rtl/clk_tick_ctrl.sv
// Multi-channel clock-enable scheduler: start/stop/drain FSM, config decode, NUM_CH tick channels.
// Optional CLK_TICK_CNT_EN adds a 32-bit count of channel-0 ticks on port tick_cnt.
module clk_tick_ctrl
    import clk_tick_pkg::*;
#(
    parameter int unsigned CLK_FREQ = 100,
    parameter int unsigned NUM_CH   = 4,
    parameter int unsigned DIV_W    = CLK_TICK_DIV_W_DEF,
    localparam int unsigned CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [DIV_W-1:0]  cfg_div,
    input  logic              cfg_en,
    input  logic              start,
    input  logic              stop,
    output logic              busy,
    output logic [NUM_CH-1:0] tick
`ifdef CLK_TICK_CNT_EN
    ,
    output logic [31:0]       tick_cnt
`endif
);

    if (NUM_CH < 1 || NUM_CH > 16 || CLK_FREQ == 0) begin : g_bad_param
        $error("clk_tick_ctrl: unsupported parameter values");
    end

    clk_tick_state_e   state_q, state_d;
    logic [NUM_CH-1:0] running;
    logic              idle, drain, cfg_acc, start_acc;

    assign idle      = (state_q == IDLE);
    assign drain     = (state_q == DRAIN);
    assign cfg_ready = !drain;
    assign busy      = !idle;
    assign cfg_acc   = cfg_valid && cfg_ready;
    assign start_acc = idle && start && !stop;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start && !stop) state_d = RUN;
            RUN:     if (stop) state_d = DRAIN;
            DRAIN:   if (running == '0) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Out-of-range channel numbers match no channel, so such writes are accepted and dropped.
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic wr;
        assign wr = cfg_acc && (32'(cfg_ch) == 32'(i));

        clk_tick_chan #(
            .DIV_W (DIV_W)
        ) u_chan (
            .clk       (clk),
            .rst_n     (rst_n),
            .idle_i    (idle),
            .drain_i   (drain),
            .wr_i      (wr),
            .wr_div_i  (cfg_div),
            .wr_en_i   (cfg_en),
            .tick_o    (tick[i]),
            .running_o (running[i])
        );
    end

`ifdef CLK_TICK_CNT_EN
    logic [31:0] tick_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_cnt_q <= '0;
        end else if (start_acc) begin
            tick_cnt_q <= '0;
        end else if (tick[0]) begin
            tick_cnt_q <= tick_cnt_q + 32'd1;
        end
    end

    assign tick_cnt = tick_cnt_q;
`else
    // No channel-0 tick counter in this build.
`endif

endmodule

// File: tb/tb_clk_tick_ctrl.sv
// Directed self-checking bench for clk_tick_ctrl (NUM_CH=4, DIV_W=16, 100 MHz clock).
module tb_clk_tick_ctrl;

    logic        clk;
    logic        rst_n;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [1:0]  cfg_ch;
    logic [15:0] cfg_div;
    logic        cfg_en;
    logic        start;
    logic        stop;
    logic        busy;
    logic [3:0]  tick;
`ifdef CLK_TICK_CNT_EN
    logic [31:0] tick_cnt;
`endif

    int n_chk;
    int n_fail;

    clk_tick_ctrl #(
        .CLK_FREQ (100),
        .NUM_CH   (4),
        .DIV_W    (16)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_ch    (cfg_ch),
        .cfg_div   (cfg_div),
        .cfg_en    (cfg_en),
        .start     (start),
        .stop      (stop),
        .busy      (busy),
        .tick      (tick)
`ifdef CLK_TICK_CNT_EN
        ,
        .tick_cnt  (tick_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cfg(input logic [1:0] ch, input logic [15:0] div, input logic en);
        cfg_valid = 1'b1;
        cfg_ch    = ch;
        cfg_div   = div;
        cfg_en    = en;
        step();
        cfg_valid = 1'b0;
    endtask

    initial begin
        logic [3:0] exp_t;
        n_chk     = 0;
        n_fail    = 0;
        rst_n     = 1'b0;
        cfg_valid = 1'b0;
        cfg_ch    = '0;
        cfg_div   = '0;
        cfg_en    = 1'b0;
        start     = 1'b0;
        stop      = 1'b0;
        step();
        step();
        check("rst_tick", tick, 0);
        check("rst_busy", busy, 0);
        check("rst_ready", cfg_ready, 1);
`ifdef CLK_TICK_CNT_EN
        check("rst_tick_cnt", tick_cnt, 0);
`endif
        rst_n = 1'b1;
        step();

        // ch0 div=4: tick after the 4th, 8th, 12th edge following start acceptance
        cfg(2'd0, 16'd4, 1'b1);
        start = 1'b1;
        step();
        start = 1'b0;
        check("t1_busy", busy, 1);
        check("t1_tick0", tick, 0);
        for (int k = 1; k <= 12; k++) begin
            step();
            check("t1_tick", tick, (k % 4 == 0) ? 1 : 0);
        end
`ifdef CLK_TICK_CNT_EN
        check("t1_tick_cnt", tick_cnt, 2);
`endif

        // div 4 -> 10 mid-period: current period finishes at edge 16, then 10-cycle period
        cfg(2'd0, 16'd10, 1'b1);
        check("t3_tick13", tick, 0);
        for (int k = 14; k <= 36; k++) begin
            step();
            check("t3_tick", tick, (k == 16 || k == 26 || k == 36) ? 1 : 0);
        end

        // stop at edge 37: last ch0 tick at edge 46, IDLE at edge 47
        stop = 1'b1;
        step();
        stop = 1'b0;
        check("d1_busy", busy, 1);
        check("d1_ready", cfg_ready, 0);
        for (int k = 38; k <= 47; k++) begin
            step();
            check("d1_tick", tick, (k == 46) ? 1 : 0);
            check("d1_busy", busy, (k <= 46) ? 1 : 0);
            check("d1_ready", cfg_ready, (k > 46) ? 1 : 0);
        end

        // ch1 div=0 behaves as div=1: tick every cycle
        cfg(2'd0, 16'd10, 1'b0);
        cfg(2'd1, 16'd0, 1'b1);
        start = 1'b1;
        step();
        start = 1'b0;
        check("t2_tick0", tick, 0);
`ifdef CLK_TICK_CNT_EN
        check("t2_tick_cnt_clr", tick_cnt, 0);
`endif
        for (int k = 1; k <= 5; k++) begin
            step();
            check("t2_tick", tick, 4'b0010);
        end
        stop = 1'b1;
        step();
        stop = 1'b0;
        check("t2_stop_tick", tick, 4'b0010);
        check("t2_stop_busy", busy, 1);
        step();
        check("t2_last_tick", tick, 4'b0010);
        check("t2_last_busy", busy, 1);
        step();
        check("t2_idle_tick", tick, 0);
        check("t2_idle_busy", busy, 0);

        // ch0 div=8, ch2 div=3, stop at edge 11: one more tick each (edge 12 and 16)
        cfg(2'd1, 16'd1, 1'b0);
        cfg(2'd0, 16'd8, 1'b1);
        cfg(2'd2, 16'd3, 1'b1);
        start = 1'b1;
        step();
        start = 1'b0;
        for (int k = 1; k <= 18; k++) begin
            if (k == 11) stop = 1'b1;
            step();
            stop = 1'b0;
            if (k <= 10) begin
                exp_t = {1'b0, (k % 3 == 0), 1'b0, (k % 8 == 0)};
            end else begin
                exp_t = {1'b0, (k == 12), 1'b0, (k == 16)};
            end
            check("t4_tick", tick, exp_t);
            check("t4_busy", busy, (k <= 16) ? 1 : 0);
            check("t4_ready", cfg_ready, (k >= 11 && k <= 16) ? 0 : 1);
        end

        // start and stop together in IDLE, then stop alone in IDLE
        start = 1'b1;
        stop  = 1'b1;
        step();
        start = 1'b0;
        check("t5_both_busy", busy, 0);
        step();
        stop = 1'b0;
        check("t5_stop_busy", busy, 0);
        check("t5_stop_tick", tick, 0);

        // no channels enabled; enable ch3 (div=2) in RUN, then disable it in RUN
        cfg(2'd0, 16'd8, 1'b0);
        cfg(2'd2, 16'd3, 1'b0);
        start = 1'b1;
        step();
        start = 1'b0;
        check("t6_busy", busy, 1);
        cfg(2'd3, 16'd2, 1'b1);
        check("t6_en_tick", tick, 0);
        for (int j = 1; j <= 4; j++) begin
            step();
            check("t6_tick", tick, (j % 2 == 0) ? 4'b1000 : 4'b0000);
        end
        cfg(2'd3, 16'd2, 1'b0);
        check("t6_dis_tick", tick, 0);
        step();
        check("t6_final_tick", tick, 4'b1000);
        step();
        check("t6_off_tick", tick, 0);
        step();
        check("t6_off_tick2", tick, 0);
        stop = 1'b1;
        step();
        stop = 1'b0;
        check("t6_drain_busy", busy, 1);
        check("t6_drain_ready", cfg_ready, 0);
        step();
        check("t6_idle_busy", busy, 0);
        check("t6_idle_ready", cfg_ready, 1);

        // asynchronous reset while ch0 ticks every cycle
        cfg(2'd0, 16'd1, 1'b1);
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        check("t7_run_tick", tick, 1);
        #3;
        rst_n = 1'b0;
        #1;
        check("t7_rst_tick", tick, 0);
        check("t7_rst_busy", busy, 0);
        check("t7_rst_ready", cfg_ready, 1);
`ifdef CLK_TICK_CNT_EN
        check("t7_rst_tick_cnt", tick_cnt, 0);
`endif
        #2;
        rst_n = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
        check("t7_restart_busy", busy, 1);
        for (int k = 1; k <= 3; k++) begin
            step();
            check("t7_no_en_tick", tick, 0);
        end
        stop = 1'b1;
        step();
        stop = 1'b0;
        step();
        check("t7_end_busy", busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
